// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM stage of the pipelined CPU.
// It takes one load or store at a time and holds the pipeline with stall_o for
// LATENCY cycles. It then completes with a one-cycle ack_o. Load data appears
// on rdata_o in that ack cycle and stays there until the next load completes.
//
// Parameters:
//   DEPTH   - number of 32-bit words; word index is addr_i[31:2]
//   LATENCY - cycles from accept to ack, legal range 1..15
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   mem_read_i   in   load request
//   mem_write_i  in   store request
//   addr_i       in   byte address [31:0]
//   wdata_i      in   store data [31:0]
//   stall_o      out  freeze pipeline (combinational on state and request)
//   ack_o        out  one-cycle completion pulse
//   rdata_o      out  load data [31:0]
//   err_o        out  sticky error flag: conflicting request, misaligned
//                     access or out-of-range access
//
// Optional feature, enabled by defining DMEM_PERF_CNT_EN:
//   rd_cnt_o     out  completed loads [31:0]
//   wr_cnt_o     out  completed stores [31:0]
//   stall_cnt_o  out  cycles with stall_o high [31:0]
//
// Handshake: there is no ready signal. A request is presented while
// mem_read_i or mem_write_i is high. It is accepted in an IDLE cycle when
// exactly one of them is high. The CPU holds its request stable while stall_o
// is high. The access ends with the single ack_o cycle. A request present
// during the ack cycle is not accepted.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        req_rd, req_wr, req_valid, req_both;
    logic        stall;
    logic        commit;
    logic        acc_wr;
    logic [29:0] acc_idx;
    logic [31:0] acc_wdata;
    logic        acc_in_range;
    logic        mem_we;

    always_comb begin
        req_rd    = mem_read_i & ~mem_write_i;
        req_wr    = mem_write_i & ~mem_read_i;
        req_valid = req_rd | req_wr;
        req_both  = mem_read_i & mem_write_i;

        // With LATENCY=1 the commit happens on the accept edge itself. At that
        // point the latched copies are not loaded yet, so the commit uses the
        // live inputs while in IDLE.
        if (state_q == IDLE) begin
            acc_wr    = req_wr;
            acc_idx   = addr_i[31:2];
            acc_wdata = wdata_i;
        end else begin
            acc_wr    = op_wr_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end
        acc_in_range = ({2'b00, acc_idx} < 32'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall   = 1'b0;
        commit  = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    op_wr_d = req_wr;
                    idx_d   = addr_i[31:2];
                    wdata_d = wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    if (addr_i[1:0] != 2'b00 || !acc_in_range) begin
                        err_d = 1'b1;
                    end
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end else if (req_both) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out-of-range stores are dropped and out-of-range loads read zero.
        if (commit) begin
            if (acc_wr) begin
                mem_we = acc_in_range;
            end else begin
                rdata_d = acc_in_range ? mem_q[acc_idx[AW-1:0]] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= 30'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is not cleared by reset. A store that has not committed when
    // reset arrives is discarded.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[acc_idx[AW-1:0]] <= acc_wdata;
        end
    end

    assign stall_o = stall & ~rst_i;
    assign ack_o   = (state_q == RESP) & ~rst_i;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == RESP) begin
            if (op_wr_q) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
        if (stall_o) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q    <= 32'd0;
            wr_cnt_q    <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the pipelined CPU's MEM stage.
- Accepts one load/store request at a time from the EX/MEM pipeline register, holds the CPU with stall_o for a fixed latency, then completes with a one-cycle ack_o and read data.
- Replaces the single-cycle data memory when modelling realistic memory latency. The CPU's hazard logic freezes PC, IF/ID, ID/EX and EX/MEM while stall_o is high.

Parameters:
- DEPTH, 256: number of 32-bit words; word index = addr_i[31:2].
- LATENCY, 3: cycles from accept to ack. Legal range 1..15; values outside the range are a static error.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mem_read_i  input  1  load request (EX/MEM MemRead).
- mem_write_i  input  1  store request (EX/MEM MemWrite).
- addr_i  input  32  byte address (EX/MEM ALU result).
- wdata_i  input  32  store data (EX/MEM rs2 data).
- stall_o  output  1  freeze pipeline; combinational on state and request inputs.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load data; valid when ack_o is high for a load.
- err_o  output  1  sticky error flag.

Behaviour:
- Reset values: state=IDLE, counter=0, ack_o=0, rdata_o=0, err_o=0. stall_o=0 while rst_i is high. Memory array contents are not cleared by reset.
- States: IDLE, BUSY, RESP.
- IDLE, valid request (exactly one of mem_read_i/mem_write_i high):
  - Accept in cycle T: latch op, word index and wdata.
  - stall_o=1 combinationally in cycle T.
  - Counter loads LATENCY-1. Next state is BUSY if LATENCY>1, else RESP.
- BUSY: stall_o=1. Counter decrements each cycle; at counter==1 the next state is RESP. The CPU holds its request inputs stable; the block ignores them.
- Entering RESP (at the edge ending cycle T+LATENCY-1):
  - Stores commit to the array.
  - Loads capture the array word into rdata_o.
- RESP (cycle T+LATENCY): ack_o=1, stall_o=0; the pipeline advances. Inputs present in this cycle are not accepted. Next state is IDLE.
- Request rate: the earliest following accept is cycle T+LATENCY+1. Total occupancy per access is LATENCY+1 cycles.
- rdata_o holds its value until the next load completes. Stores do not change rdata_o.
- Read-after-write: a load accepted after a store's ack returns the stored value.
- Both mem_read_i and mem_write_i high in IDLE: the request is not accepted, stall_o=0, no ack, err_o set.
- Misaligned access (addr_i[1:0]!=0): accepted as normal, addr_i[1:0] ignored, err_o set.
- Out of range (word index >= DEPTH):
  - Full latency is observed and ack_o is produced.
  - Loads return 0; stores are dropped.
  - err_o set.
- err_o is cleared only by reset.
- Reset mid-operation (BUSY or RESP): return to IDLE. A store not yet committed is discarded. ack_o is not generated for the aborted access.
- No request in IDLE: outputs are idle (stall_o=0, ack_o=0).

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined:
  - Adds output rd_cnt_o [31:0] and output wr_cnt_o [31:0].
  - Each increments by 1 in the RESP cycle of a completed load or store, including out-of-range accesses.
  - Both wrap at 2^32 to 0 and reset to 0.
  - Also adds output stall_cnt_o [31:0], which counts cycles with stall_o=1.
- When undefined: these ports and their registers do not exist, and the block's behaviour is otherwise identical.

Test Plan:
- Store, LATENCY=3, DEPTH=256: mem_write_i=1, addr=0x10, wdata=0xDEADBEEF at cycle 0 -> stall_o=1 in cycles 0-2, ack_o=1 only in cycle 3, err_o=0.
- Load after that store: mem_read_i=1, addr=0x10 at cycle 4 -> stall_o=1 in cycles 4-6, ack_o=1 in cycle 7, rdata_o=0xDEADBEEF from cycle 7 until the next load.
- Back-to-back loads with request inputs held high continuously at addr=0x10 -> accepts at cycles 0 and 4; the RESP-cycle input is not re-accepted; two ack pulses at cycles 3 and 7.
- Error cases:
  - Load addr=0x400 (index 256) -> ack at +3, rdata_o=0, err_o=1 and remains 1.
  - After reset, load addr=0x12 -> returns word 4, err_o=1.
  - After reset, read and write both high -> stall_o=0, no ack, err_o=1.
- Reset mid-store: store 0x12345678 to addr=0x20, rst_i=1 in cycle 1 -> no ack; a subsequent load of 0x20 returns the previous contents.
- LATENCY=1, with DMEM_PERF_CNT_EN defined: 2 stores, then 3 loads, issued back-to-back -> each access stalls 1 cycle and acks the next cycle; wr_cnt_o=2, rd_cnt_o=3, stall_cnt_o=5.
